// File: rtl/game_ctl.sv
// Pong rally sequencer: serve/rally/point/game-over control, paddle contact
// checks at both goal lines, horizontal bounce pulses and score keeping.
module game_ctl #(
    parameter int BALL_DIAMETER = 16,
    parameter int PADDLE_HEIGHT = 96,
    parameter int LEFT_LIMIT    = 24,
    parameter int RIGHT_LIMIT   = 984,
    parameter int WIN_SCORE     = 9,
    parameter int PAUSE_CYCLES  = 1000000
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] ball_xpos,
    input  logic [11:0] ball_ypos,
    input  logic [11:0] paddle_l_ypos,
    input  logic [11:0] paddle_r_ypos,
    output logic        ball_run,
    output logic        ball_reset,
    output logic        bounce_x,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        serve_side,
    output logic        game_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RALLY = 3'd1,
        S_POINT = 3'd2,
        S_SERVE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [12:0] BALL_D13   = 13'(BALL_DIAMETER);
    localparam logic [12:0] PAD_H13    = 13'(PADDLE_HEIGHT);
    localparam logic [11:0] LEFT_LIM   = 12'(LEFT_LIMIT);
    localparam logic [11:0] RIGHT_LIM  = 12'(RIGHT_LIMIT);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
    localparam logic [23:0] PAUSE_LAST = 24'(PAUSE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        arm_l_q, arm_l_d;
    logic        arm_r_q, arm_r_d;
    logic [3:0]  score_l_q, score_l_d;
    logic [3:0]  score_r_q, score_r_d;
    logic        serve_q, serve_d;
    logic        bounce_q, bounce_d;
    logic        run_q, run_d;
    logic        breset_q, breset_d;
    logic        over_q, over_d;
    logic        mouse_left_q;
    logic        btn_live_q;

    logic        click;
    logic        at_left, at_right;
    logic        hit_l, hit_r;
    logic [12:0] ball_top13, ball_bot13;
    logic [12:0] pad_l_top13, pad_r_top13;

    // btn_live_q masks the first cycle out of reset so a held button is not a click
    assign click = mouse_left & ~mouse_left_q & btn_live_q;

    assign ball_top13  = {1'b0, ball_ypos};
    assign ball_bot13  = ball_top13 + BALL_D13;
    assign pad_l_top13 = {1'b0, paddle_l_ypos};
    assign pad_r_top13 = {1'b0, paddle_r_ypos};

    assign hit_l    = (ball_bot13 > pad_l_top13) && (ball_top13 < (pad_l_top13 + PAD_H13));
    assign hit_r    = (ball_bot13 > pad_r_top13) && (ball_top13 < (pad_r_top13 + PAD_H13));
    assign at_left  = arm_l_q && (ball_xpos <= LEFT_LIM);
    assign at_right = arm_r_q && (ball_xpos >= RIGHT_LIM);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arm_l_d   = arm_l_q;
        arm_r_d   = arm_r_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        serve_d   = serve_q;
        bounce_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                score_l_d = 4'd0;
                score_r_d = 4'd0;
                if (click) begin
                    state_d = S_RALLY;
                    arm_l_d = 1'b1;
                    arm_r_d = 1'b1;
                end
            end
            S_RALLY: begin
                // Left takes priority; the right side is not looked at that cycle
                if (at_left) begin
                    if (hit_l) begin
                        bounce_d = 1'b1;
                        arm_l_d  = 1'b0;
                        arm_r_d  = 1'b1;
                    end else begin
                        score_r_d = score_r_q + 4'd1;
                        serve_d   = 1'b0;
                        state_d   = S_POINT;
                    end
                end else if (at_right) begin
                    if (hit_r) begin
                        bounce_d = 1'b1;
                        arm_r_d  = 1'b0;
                        arm_l_d  = 1'b1;
                    end else begin
                        score_l_d = score_l_q + 4'd1;
                        serve_d   = 1'b1;
                        state_d   = S_POINT;
                    end
                end
            end
            S_POINT: begin
                if (cnt_q == PAUSE_LAST) begin
                    cnt_d   = 24'd0;
                    state_d = (score_l_q == WIN || score_r_q == WIN) ? S_OVER : S_SERVE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_SERVE: begin
                if (click) begin
                    state_d = S_RALLY;
                    arm_l_d = 1'b1;
                    arm_r_d = 1'b1;
                end
            end
            S_OVER: begin
                if (click) begin
                    state_d   = S_IDLE;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 24'd0;
            end
        endcase

        run_d    = (state_q == S_RALLY);
        breset_d = (state_q != S_RALLY);
        over_d   = (state_q == S_OVER);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 24'd0;
            arm_l_q      <= 1'b0;
            arm_r_q      <= 1'b0;
            score_l_q    <= 4'd0;
            score_r_q    <= 4'd0;
            serve_q      <= 1'b0;
            bounce_q     <= 1'b0;
            run_q        <= 1'b0;
            breset_q     <= 1'b1;
            over_q       <= 1'b0;
            mouse_left_q <= 1'b0;
            btn_live_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            arm_l_q      <= arm_l_d;
            arm_r_q      <= arm_r_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            serve_q      <= serve_d;
            bounce_q     <= bounce_d;
            run_q        <= run_d;
            breset_q     <= breset_d;
            over_q       <= over_d;
            mouse_left_q <= mouse_left;
            btn_live_q   <= 1'b1;
        end
    end

    assign ball_run   = run_q;
    assign ball_reset = breset_q;
    assign bounce_x   = bounce_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign serve_side = serve_q;
    assign game_over  = over_q;

endmodule

// File: tb/tb_game_ctl.sv
// Bench for game_ctl: directed rally/point/win/reset scenarios plus random play,
// every output compared each cycle against a behavioural rally model.
module tb_game_ctl;

    localparam int BALL_D    = 16;
    localparam int PAD_H     = 96;
    localparam int LEFT_LIM  = 24;
    localparam int RIGHT_LIM = 984;
    localparam int WIN       = 2;
    localparam int PAUSE     = 8;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        mouse_left = 1'b0;
    logic [11:0] ball_xpos = 12'd500;
    logic [11:0] ball_ypos = 12'd290;
    logic [11:0] paddle_l_ypos = 12'd300;
    logic [11:0] paddle_r_ypos = 12'd300;
    logic        ball_run, ball_reset, bounce_x, serve_side, game_over;
    logic [3:0]  score_l, score_r;

    int checks = 0;
    int errors = 0;
    int bounce_cnt = 0;
    int b0;

    game_ctl #(
        .BALL_DIAMETER(BALL_D), .PADDLE_HEIGHT(PAD_H), .LEFT_LIMIT(LEFT_LIM),
        .RIGHT_LIMIT(RIGHT_LIM), .WIN_SCORE(WIN), .PAUSE_CYCLES(PAUSE)
    ) dut (
        .pclk(pclk), .rst(rst), .mouse_left(mouse_left),
        .ball_xpos(ball_xpos), .ball_ypos(ball_ypos),
        .paddle_l_ypos(paddle_l_ypos), .paddle_r_ypos(paddle_r_ypos),
        .ball_run(ball_run), .ball_reset(ball_reset), .bounce_x(bounce_x),
        .score_l(score_l), .score_r(score_r), .serve_side(serve_side),
        .game_over(game_over)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: game phase, pending contact checks, countdown and scores
    typedef enum {M_IDLE, M_RALLY, M_POINT, M_SERVE, M_OVER} phase_t;
    phase_t phase;
    int     prev_ml;
    bit     want_l, want_r, m_click;
    int     sl, sr, serve, pause_left;
    bit     e_run, e_breset, e_bounce, e_over;

    function automatic bit overlaps(input int by, input int py);
        return (by + BALL_D > py) && (by < py + PAD_H);
    endfunction

    always @(posedge pclk or negedge rst) begin
        if (!rst) begin
            phase = M_IDLE; prev_ml = -1; want_l = 0; want_r = 0;
            sl = 0; sr = 0; serve = 0; pause_left = 0;
            e_run = 0; e_breset = 1; e_bounce = 0; e_over = 0;
        end else begin
            m_click = (mouse_left == 1'b1) && (prev_ml == 0);
            prev_ml = int'(mouse_left);
            e_run    = (phase == M_RALLY);
            e_breset = !e_run;
            e_over   = (phase == M_OVER);
            e_bounce = 0;
            case (phase)
                M_IDLE, M_SERVE:
                    if (m_click) begin phase = M_RALLY; want_l = 1; want_r = 1; end
                M_RALLY:
                    if (want_l && int'(ball_xpos) <= LEFT_LIM) begin
                        if (overlaps(int'(ball_ypos), int'(paddle_l_ypos))) begin
                            e_bounce = 1; want_l = 0; want_r = 1;
                        end else begin
                            sr++; serve = 0; phase = M_POINT; pause_left = PAUSE;
                        end
                    end else if (want_r && int'(ball_xpos) >= RIGHT_LIM) begin
                        if (overlaps(int'(ball_ypos), int'(paddle_r_ypos))) begin
                            e_bounce = 1; want_r = 0; want_l = 1;
                        end else begin
                            sl++; serve = 1; phase = M_POINT; pause_left = PAUSE;
                        end
                    end
                M_POINT: begin
                    pause_left--;
                    if (pause_left == 0) phase = (sl == WIN || sr == WIN) ? M_OVER : M_SERVE;
                end
                M_OVER:
                    if (m_click) begin phase = M_IDLE; sl = 0; sr = 0; end
                default: phase = M_IDLE;
            endcase
        end
    end

    always @(negedge pclk) begin
        check("ball_run", int'(ball_run), int'(e_run));
        check("ball_reset", int'(ball_reset), int'(e_breset));
        check("bounce_x", int'(bounce_x), int'(e_bounce));
        check("game_over", int'(game_over), int'(e_over));
        check("score_l", int'(score_l), sl);
        check("score_r", int'(score_r), sr);
        check("serve_side", int'(serve_side), serve);
        if (bounce_x) bounce_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge pclk);
            #1;
        end
    endtask

    task automatic click_btn();
        mouse_left = 1'b1;
        step(2);
        mouse_left = 1'b0;
    endtask

    int xs[7] = '{10, 24, 25, 500, 983, 984, 1000};

    initial begin
        #2 rst = 1'b0;
        mouse_left = 1'b1;
        step(3);
        rst = 1'b1;
        step(4);
        check("held_no_start_run", int'(ball_run), 0);
        check("held_no_start_reset", int'(ball_reset), 1);

        mouse_left = 1'b0;
        step(1);
        mouse_left = 1'b1;
        step(1);
        check("start_run_1cyc", int'(ball_run), 0);
        step(1);
        check("start_run_2cyc", int'(ball_run), 1);
        check("start_score_l", int'(score_l), 0);
        check("start_score_r", int'(score_r), 0);
        mouse_left = 1'b0;

        // Left hit with the ball lingering at the limit
        b0 = bounce_cnt;
        ball_xpos = 12'd30; step(2);
        ball_xpos = 12'd24; step(5);
        ball_xpos = 12'd500; step(2);
        check("left_hit_pulses", bounce_cnt - b0, 1);
        check("left_hit_score_r", int'(score_r), 0);

        ball_xpos = 12'd984; step(3);
        ball_xpos = 12'd500; step(2);

        // Contact edge: 284 + 16 == 300 is a miss
        ball_ypos = 12'd284; ball_xpos = 12'd24; step(1);
        ball_xpos = 12'd500; ball_ypos = 12'd290;
        check("edge_miss_score_r", int'(score_r), 1);
        check("edge_miss_serve", int'(serve_side), 0);
        step(1);
        check("point_ball_reset", int'(ball_reset), 1);
        click_btn();
        step(10);
        check("point_click_ignored", int'(ball_run), 0);
        click_btn();
        check("serve_to_rally", int'(ball_run), 1);

        b0 = bounce_cnt;
        ball_ypos = 12'd285; ball_xpos = 12'd24; step(3);
        ball_xpos = 12'd500; step(1);
        check("edge_hit_pulses", bounce_cnt - b0, 1);
        check("edge_hit_score_r", int'(score_r), 1);

        // Two right misses reach the win score
        ball_ypos = 12'd0; ball_xpos = 12'd984; step(1);
        ball_xpos = 12'd500;
        check("right_miss_score_l", int'(score_l), 1);
        check("right_miss_serve", int'(serve_side), 1);
        step(12);
        click_btn();
        ball_xpos = 12'd984; step(1);
        ball_xpos = 12'd500;
        check("win_score_l", int'(score_l), 2);
        step(11);
        check("win_game_over", int'(game_over), 1);
        check("win_ball_reset", int'(ball_reset), 1);
        mouse_left = 1'b1; step(1);
        check("over_clear_l", int'(score_l), 0);
        check("over_clear_r", int'(score_r), 0);
        mouse_left = 1'b0; step(2);
        check("over_exit", int'(game_over), 0);

        // Random play
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(7) == 0) mouse_left = ~mouse_left;
            if ($urandom_range(3) == 0) ball_xpos = 12'(xs[$urandom_range(6)]);
            if ($urandom_range(31) == 0) ball_ypos = 12'($urandom_range(4095, 4000));
            else ball_ypos = 12'($urandom_range(420, 200));
            if ($urandom_range(15) == 0) paddle_l_ypos = 12'($urandom_range(380, 220));
            if ($urandom_range(15) == 0) paddle_r_ypos = 12'($urandom_range(380, 220));
            if ($urandom_range(63) == 0) paddle_r_ypos = 12'($urandom_range(4095, 4000));
            step(1);
        end

        // Asynchronous reset in the middle of a rally
        mouse_left = 1'b0; ball_xpos = 12'd500; ball_ypos = 12'd290;
        paddle_l_ypos = 12'd300; paddle_r_ypos = 12'd300;
        rst = 1'b0; step(1); rst = 1'b1; step(2);
        click_btn();
        ball_ypos = 12'd0; ball_xpos = 12'd24; step(1);
        ball_xpos = 12'd500; ball_ypos = 12'd290;
        step(10);
        click_btn();
        step(3);
        check("pre_reset_run", int'(ball_run), 1);
        check("pre_reset_score_r", int'(score_r), 1);
        @(posedge pclk);
        #2 rst = 1'b0;
        #1;
        check("async_run", int'(ball_run), 0);
        check("async_reset", int'(ball_reset), 1);
        check("async_score_r", int'(score_r), 0);
        check("async_score_l", int'(score_l), 0);
        step(2);
        rst = 1'b1;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
